// File: rtl/wb_timer_irq.sv
// wb_timer_irq: 32-bit prescaled timer, Wishbone classic slave, level IRQ.
// Ports: clk_i, rstn (sync, active-low), wishbone (adr/dat/sel/we/cyc/stb/ack/err), irq_o.
module wb_timer_irq #(
  parameter int WB_ADDR_WIDTH = 32,
  parameter int WB_DATA_WIDTH = 32,
  parameter int PRESCALE_BITS = 16
) (
  input  logic                     clk_i,
  input  logic                     rstn,
  input  logic [WB_ADDR_WIDTH-1:0] adr_i,
  input  logic [WB_DATA_WIDTH-1:0] dat_i,
  output logic [WB_DATA_WIDTH-1:0] dat_o,
  input  logic [3:0]               sel_i,
  input  logic                     we_i,
  input  logic                     cyc_i,
  input  logic                     stb_i,
  output logic                     ack_o,
  output logic                     err_o,
  output logic                     irq_o
);

  logic                     en;
  logic                     auto_rl;
  logic                     irq_en;
  logic                     pend;
  logic [31:0]              count;
  logic [31:0]              compare;
  logic [PRESCALE_BITS-1:0] prescale;
  logic [PRESCALE_BITS-1:0] pscnt;

  logic        acc;
  logic        wr;
  logic [2:0]  idx;
  logic        wr_ctrl;
  logic        wr_stat;
  logic        wr_cnt;
  logic        wr_cmp;
  logic        wr_pre;
  logic        tick;
  logic        match;
  logic [31:0] rdata;

  logic unused_ok;
  assign unused_ok = ^{sel_i, adr_i[WB_ADDR_WIDTH-1:5],
                       adr_i[1:0]};

  assign err_o = 1'b0;

  // ~ack_o makes every access a single-cycle ack pulse
  assign acc = cyc_i & stb_i & ~ack_o;
  assign wr  = acc & we_i;
  assign idx = adr_i[4:2];

  assign wr_ctrl = wr && (idx == 3'd0);
  assign wr_stat = wr && (idx == 3'd1);
  assign wr_cnt  = wr && (idx == 3'd2);
  assign wr_cmp  = wr && (idx == 3'd3);
  assign wr_pre  = wr && (idx == 3'd4);

  assign tick  = en && (pscnt == prescale);
  // a bus write to COUNT suppresses match evaluation
  assign match = tick && !wr_cnt && (count == compare);

  always_comb begin
    rdata = '0;
    unique case (idx)
      3'd0:    rdata = {29'd0, irq_en, auto_rl, en};
      3'd1:    rdata = {31'd0, pend};
      3'd2:    rdata = count;
      3'd3:    rdata = compare;
      3'd4:    rdata = {{(32-PRESCALE_BITS){1'b0}}, prescale};
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn) begin
      en       <= 1'b0;
      auto_rl  <= 1'b0;
      irq_en   <= 1'b0;
      pend     <= 1'b0;
      count    <= '0;
      compare  <= '0;
      prescale <= '0;
      pscnt    <= '0;
      ack_o    <= 1'b0;
      dat_o    <= '0;
      irq_o    <= 1'b0;
    end else begin
      ack_o <= acc;
      dat_o <= acc ? rdata : '0;
      irq_o <= pend & irq_en;

      if (wr_ctrl || wr_pre || !en || tick)
        pscnt <= '0;
      else
        pscnt <= pscnt + 1'b1;

      if (wr_cnt)
        count <= dat_i;
      else if (tick) begin
        if (match)
          count <= auto_rl ? 32'd0 : count;
        else
          count <= count + 32'd1;
      end

      // bus write to CTRL beats the one-shot auto-clear
      if (wr_ctrl) begin
        en      <= dat_i[0];
        auto_rl <= dat_i[1];
        irq_en  <= dat_i[2];
      end else if (match && !auto_rl) begin
        en <= 1'b0;
      end

      // a new match beats a simultaneous W1C
      if (match)
        pend <= 1'b1;
      else if (wr_stat && dat_i[0])
        pend <= 1'b0;

      if (wr_cmp)
        compare <= dat_i;
      if (wr_pre)
        prescale <= dat_i[PRESCALE_BITS-1:0];
    end
  end

endmodule
